// File: rtl/battery_pkg.sv
// Shared types and defaults for the battery pickup sprite renderer.
package battery_pkg;

  // Pickup lifecycle: not present, collectable, blinking out after collection.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLINK  = 2'd2
  } state_e;

  // Palette index that the sprite art uses for "no pixel here" (magenta F0D).
  localparam logic [3:0] TRANSP_IDX = 4'h2;

  localparam int COORD_W          = 10;
  localparam int DEF_SPR_W        = 32;
  localparam int DEF_SPR_H        = 32;
  localparam int DEF_NUM_FRAMES   = 4;
  localparam int DEF_FRAME_PERIOD = 15;
  localparam int DEF_BLINK_TICKS  = 60;

endpackage

// File: rtl/battery_anim_timer.sv
// Vsync-tick prescaler for the pickup: charge-level animation frame index
// while collectable, and the post-collect blink counter with its done pulse.
module battery_anim_timer
  import battery_pkg::*;
#(
  parameter int NUM_FRAMES   = DEF_NUM_FRAMES,
  parameter int FRAME_PERIOD = DEF_FRAME_PERIOD,
  parameter int BLINK_TICKS  = DEF_BLINK_TICKS,
  parameter int FRAME_W      = $clog2(NUM_FRAMES),
  parameter int PRE_W        = $clog2(FRAME_PERIOD),
  parameter int BLINK_W      = $clog2(BLINK_TICKS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               vsync_tick_i,
  input  logic               clear_i,        // spawn accepted: restart animation
  input  logic               frame_en_i,     // animation advances only while collectable
  input  logic               blink_start_i,  // collect accepted: restart blink count
  input  logic               blink_en_i,     // blink count advances only while blinking
  output logic [FRAME_W-1:0] frame_o,
  output logic               blink_visible_o,
  output logic               blink_done_o
);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BLINK_W-1:0] blink_q, blink_d;

  // Next-state for prescaler, frame index and blink counter; clears take priority over ticks.
  always_comb begin
    pre_d        = pre_q;
    frame_d      = frame_q;
    blink_d      = blink_q;
    blink_done_o = 1'b0;
    if (clear_i) begin
      pre_d   = '0;
      frame_d = '0;
    end else if (frame_en_i && vsync_tick_i) begin
      if (pre_q == PRE_W'(FRAME_PERIOD - 1)) begin
        pre_d   = '0;
        frame_d = frame_q + FRAME_W'(1);  // power-of-two frame count wraps naturally
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
    if (blink_start_i) begin
      blink_d = '0;
    end else if (blink_en_i && vsync_tick_i) begin
      if (blink_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_d      = '0;
        blink_done_o = 1'b1;
      end else begin
        blink_d = blink_q + BLINK_W'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre_q   <= '0;
      frame_q <= '0;
      blink_q <= '0;
    end else begin
      pre_q   <= pre_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
    end
  end

  assign frame_o         = frame_q;
  // Four ticks shown, four ticks hidden.
  assign blink_visible_o = ~blink_q[2];

endmodule

// File: rtl/battery_sprite_renderer.sv
// Battery pickup renderer: lifecycle FSM, position registers and a two-stage
// hit/address pipeline feeding a sync sprite ROM. Output index/on for a pixel
// appear two clocks after its DrawX/DrawY.
module battery_sprite_renderer
  import battery_pkg::*;
#(
  parameter int SPR_W        = DEF_SPR_W,
  parameter int SPR_H        = DEF_SPR_H,
  parameter int NUM_FRAMES   = DEF_NUM_FRAMES,
  parameter int FRAME_PERIOD = DEF_FRAME_PERIOD,
  parameter int BLINK_TICKS  = DEF_BLINK_TICKS,
  parameter int ADDR_W       = $clog2(NUM_FRAMES * SPR_W * SPR_H)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               vsync_tick,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               spawn,
  input  logic [9:0]         spawn_x,
  input  logic [9:0]         spawn_y,
  input  logic               collect,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_data,
  output logic [3:0]         pixel_index,
  output logic               pixel_on,
  output logic               active,
  output state_e             dbg_state_o
);

  localparam int XB      = $clog2(SPR_W);
  localparam int YB      = $clog2(SPR_H);
  localparam int FRAME_W = $clog2(NUM_FRAMES);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic               active_q;
  logic               spawn_acc, collect_acc;

  logic [FRAME_W-1:0] frame;
  logic               blink_visible, blink_done;

  logic [COORD_W-1:0] dx, dy;
  logic               hit, vis;
  logic [ADDR_W-1:0]  addr_d, rom_addr_q;
  logic               hit_s1_q, vis_s1_q, hit_s2_q, vis_s2_q;

  battery_anim_timer #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_PERIOD(FRAME_PERIOD),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_timer (
    .clk_i          (Clk),
    .reset_i        (Reset),
    .vsync_tick_i   (vsync_tick),
    .clear_i        (spawn_acc),
    .frame_en_i     ((state_q == ACTIVE) && !collect),
    .blink_start_i  (collect_acc),
    .blink_en_i     (state_q == BLINK),
    .frame_o        (frame),
    .blink_visible_o(blink_visible),
    .blink_done_o   (blink_done)
  );

  // Lifecycle next-state: collect beats spawn in ACTIVE, spawn ignored while blinking.
  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    spawn_acc   = 1'b0;
    collect_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn) begin
          state_d   = ACTIVE;
          spawn_acc = 1'b1;
        end
      end
      ACTIVE: begin
        if (collect) begin
          state_d     = BLINK;
          collect_acc = 1'b1;
        end else if (spawn) begin
          spawn_acc = 1'b1;
        end
      end
      BLINK: begin
        if (blink_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (spawn_acc) begin
      pos_x_d = spawn_x;
      pos_y_d = spawn_y;
    end
  end

  // Stage 0: box test by unsigned wrap, so pixels left/above the sprite fail too.
  // No pickup exists in IDLE, so nothing is addressed there.
  always_comb begin
    dx     = DrawX - pos_x_q;
    dy     = DrawY - pos_y_q;
    hit    = (state_q != IDLE) && (dx < COORD_W'(SPR_W)) && (dy < COORD_W'(SPR_H));
    vis    = (state_q == ACTIVE) || ((state_q == BLINK) && blink_visible);
    addr_d = hit ? {frame, dy[YB-1:0], dx[XB-1:0]} : '0;
  end

  // State, position and the two pipeline stages that track the ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      active_q   <= 1'b0;
      rom_addr_q <= '0;
      hit_s1_q   <= 1'b0;
      vis_s1_q   <= 1'b0;
      hit_s2_q   <= 1'b0;
      vis_s2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      active_q   <= (state_d == ACTIVE);
      rom_addr_q <= addr_d;
      hit_s1_q   <= hit;
      vis_s1_q   <= vis;
      hit_s2_q   <= hit_s1_q;
      vis_s2_q   <= vis_s1_q;
    end
  end

  // Final stage: rom_data lines up with the twice-delayed hit/visible flags.
  always_comb begin
    pixel_on    = hit_s2_q && vis_s2_q && (rom_data != TRANSP_IDX);
    pixel_index = pixel_on ? rom_data : 4'h0;
  end

  assign rom_addr    = rom_addr_q;
  assign active      = active_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_battery_sprite_renderer.sv
// Bench for battery_sprite_renderer: directed tables/sequences, then random
// traffic checked against a tick-counting reference model.
module tb_battery_sprite_renderer;
  import battery_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, vsync_tick, spawn, collect;
  logic [9:0]  DrawX, DrawY, spawn_x, spawn_y;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data = 4'h0;
  logic [3:0]  pixel_index;
  logic        pixel_on, active;
  state_e      dbg_state_o;

  logic [3:0]  rom_mem [0:4095];
  int          total = 0;
  int          bad = 0;
  logic [4:0]  exp_q [$];

  battery_sprite_renderer dut (
    .Clk(Clk), .Reset(Reset), .vsync_tick(vsync_tick),
    .DrawX(DrawX), .DrawY(DrawY),
    .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y), .collect(collect),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_index(pixel_index), .pixel_on(pixel_on), .active(active),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and sync ROM with one cycle of read latency.
  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic park();
    DrawX = 10'd1000;
    DrawY = 10'd1000;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic do_spawn(input int x, input int y);
    spawn = 1'b1; spawn_x = 10'(x); spawn_y = 10'(y);
    step();
    spawn = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_tick = 1'b1;
      step();
      vsync_tick = 1'b0;
      step();
    end
  endtask

  // Present one pixel, return its address one clock later and its output one clock after that.
  task automatic probe(input int x, input int y, output int addr, output logic on,
                       output logic [3:0] idx);
    DrawX = 10'(x); DrawY = 10'(y);
    step();
    addr = int'(rom_addr);
    park();
    step();
    on  = pixel_on;
    idx = pixel_index;
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [3:0] rom_val;
    int         exp_addr;
    logic       exp_on;
    logic [3:0] exp_idx;
  } vec_t;

  vec_t vecs[8];

  // Reference model state.
  int m_mode, m_px, m_py, m_aticks, m_bticks;

  initial begin
    int         a;
    logic       on;
    logic [3:0] idx;

    Reset = 1'b1; vsync_tick = 1'b0; spawn = 1'b0; collect = 1'b0;
    spawn_x = '0; spawn_y = '0; DrawX = '0; DrawY = '0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'h7;
    do_reset();

    // Reset state
    check("reset_addr", rom_addr, 0);
    check("reset_on", pixel_on, 0);
    check("reset_idx", pixel_index, 0);
    check("reset_active", active, 0);
    check("reset_state", dbg_state_o, IDLE);

    // No pickup: raster sweep shows nothing
    foreach (vecs[k]) vecs[k] = '{0, 0, 4'h0, 0, 1'b0, 4'h0};
    for (int yy = 0; yy < 480; yy += 97) begin
      for (int xx = 0; xx < 640; xx += 37) begin
        DrawX = 10'(xx); DrawY = 10'(yy);
        step();
        check("idle_addr", rom_addr, 0);
        check("idle_on", pixel_on, 0);
        check("idle_active", active, 0);
      end
    end
    park();
    step();

    // Spawn and single-pixel table
    do_spawn(100, 200);
    check("spawn_active", active, 1);
    check("spawn_state", dbg_state_o, ACTIVE);
    vecs[0] = '{105, 203, 4'h7, 12'h065, 1'b1, 4'h7};
    vecs[1] = '{99,  203, 4'h7, 0,       1'b0, 4'h0};
    vecs[2] = '{132, 203, 4'h7, 0,       1'b0, 4'h0};
    vecs[3] = '{100, 200, 4'h9, 12'h000, 1'b1, 4'h9};
    vecs[4] = '{131, 231, 4'h5, 12'h3FF, 1'b1, 4'h5};
    vecs[5] = '{105, 203, 4'h2, 12'h065, 1'b0, 4'h0};
    vecs[6] = '{131, 232, 4'hC, 0,       1'b0, 4'h0};
    vecs[7] = '{100, 199, 4'hC, 0,       1'b0, 4'h0};
    for (int k = 0; k < 8; k++) begin
      rom_mem[vecs[k].exp_addr] = vecs[k].rom_val;
      probe(vecs[k].x, vecs[k].y, a, on, idx);
      check($sformatf("vec%0d_addr", k), a, vecs[k].exp_addr);
      check($sformatf("vec%0d_on", k), on, vecs[k].exp_on);
      check($sformatf("vec%0d_idx", k), idx, vecs[k].exp_idx);
    end
    rom_mem[12'h065] = 4'h7;
    rom_mem[12'h000] = 4'h7;

    // Animation frames: boundary at 14/15 ticks and wrap at 60
    do_ticks(14);
    probe(105, 203, a, on, idx);
    check("frame_14t", a, 12'h065);
    do_ticks(1);
    probe(105, 203, a, on, idx);
    check("frame_15t", a, 12'h465);
    do_ticks(15);
    probe(105, 203, a, on, idx);
    check("frame_30t", a, 12'h865);
    do_ticks(30);
    probe(105, 203, a, on, idx);
    check("frame_60t", a, 12'h065);

    // collect + spawn together: collect wins, pickup stays put and blinks
    collect = 1'b1; spawn = 1'b1; spawn_x = 10'd300; spawn_y = 10'd300;
    step();
    collect = 1'b0; spawn = 1'b0;
    check("blink_active", active, 0);
    check("blink_state", dbg_state_o, BLINK);
    probe(105, 203, a, on, idx);
    check("blink0_addr", a, 12'h065);
    check("blink0_on", on, 1);
    do_ticks(4);
    probe(105, 203, a, on, idx);
    check("blink4_on", on, 0);
    check("blink4_idx", idx, 0);
    do_ticks(3);
    probe(105, 203, a, on, idx);
    check("blink7_on", on, 0);
    do_ticks(1);
    probe(105, 203, a, on, idx);
    check("blink8_on", on, 1);
    do_ticks(51);
    check("blink59_state", dbg_state_o, BLINK);
    do_ticks(1);
    check("blink60_state", dbg_state_o, IDLE);
    check("blink60_active", active, 0);
    probe(105, 203, a, on, idx);
    check("after_blink_addr", a, 0);
    check("after_blink_on", on, 0);

    // Reset in the middle of a blinking pixel
    do_spawn(100, 200);
    collect = 1'b1;
    step();
    collect = 1'b0;
    DrawX = 10'd105; DrawY = 10'd203;
    step();
    Reset = 1'b1;
    step();
    check("midrst_on", pixel_on, 0);
    check("midrst_state", dbg_state_o, IDLE);
    check("midrst_addr", rom_addr, 0);
    Reset = 1'b0;
    park();
    step();
    do_spawn(40, 50);
    check("respawn_active", active, 1);
    rom_mem[12'h041] = 4'hB;
    probe(41, 52, a, on, idx);
    check("respawn_addr", a, 12'h041);
    check("respawn_on", on, 1);
    check("respawn_idx", idx, 4'hB);

    // Random traffic against the reference model
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? TRANSP_IDX : 4'($urandom_range(0, 15));
    park();
    do_reset();
    m_mode = 0; m_px = 0; m_py = 0; m_aticks = 0; m_bticks = 0;
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      int   dx, dy, exp_addr, fr;
      logic hit, vis, eon;
      logic [3:0] eidx;
      state_e exp_state;
      spawn      = ($urandom_range(0, 99) < 3);
      collect    = ($urandom_range(0, 99) < 4);
      vsync_tick = ($urandom_range(0, 99) < 30);
      spawn_x    = 10'($urandom_range(0, 639));
      spawn_y    = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 7) == 0) begin
        DrawX = 10'($urandom_range(0, 1023));
        DrawY = 10'($urandom_range(0, 1023));
      end else begin
        DrawX = 10'(m_px + int'($urandom_range(0, 40)) - 4);
        DrawY = 10'(m_py + int'($urandom_range(0, 40)) - 4);
      end

      dx  = (int'(DrawX) - m_px) & 1023;
      dy  = (int'(DrawY) - m_py) & 1023;
      hit = (m_mode != 0) && (dx < 32) && (dy < 32);
      fr  = (m_aticks / 15) % 4;
      exp_addr = hit ? (fr * 1024 + dy * 32 + dx) : 0;
      vis = (m_mode == 1) || ((m_mode == 2) && (((m_bticks / 4) % 2) == 0));
      eon = hit && vis && (rom_mem[exp_addr] != TRANSP_IDX);
      eidx = eon ? rom_mem[exp_addr] : 4'h0;
      exp_q.push_back({eon, eidx});

      case (m_mode)
        0: if (spawn) begin
          m_mode = 1; m_px = int'(spawn_x); m_py = int'(spawn_y); m_aticks = 0;
        end
        1: if (collect) begin
          m_mode = 2; m_bticks = 0;
        end else if (spawn) begin
          m_px = int'(spawn_x); m_py = int'(spawn_y); m_aticks = 0;
        end else if (vsync_tick) begin
          m_aticks++;
        end
        default: if (vsync_tick) begin
          m_bticks++;
          if (m_bticks == 60) m_mode = 0;
        end
      endcase

      step();
      exp_state = (m_mode == 0) ? IDLE : (m_mode == 1) ? ACTIVE : BLINK;
      check("rnd_addr", rom_addr, exp_addr);
      check("rnd_active", active, (m_mode == 1));
      check("rnd_state", dbg_state_o, exp_state);
      if (exp_q.size() == 2) check("rnd_pixel", {pixel_on, pixel_index}, exp_q.pop_front());
    end
    spawn = 1'b0; collect = 1'b0; vsync_tick = 1'b0;
    park();
    step();
    check("rnd_pixel_last", {pixel_on, pixel_index}, exp_q.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
